// File: rtl/mult_soma_desloca_if.sv
// Bus bundle for the shift-and-add multiplier: operand request in, busy/done/product out.
// Handshake: start is a request that is taken on a rising edge only while busy is low.
// Operands are captured on that same edge. While busy is high, start is ignored.
// done pulses for exactly one cycle, and produto holds its value until the next done.
interface mult_soma_desloca_if #(
  parameter int N = 8
);
  logic           start;
  logic [N-1:0]   multiplicando;
  logic [N-1:0]   multiplicador;
  logic           busy;
  logic           done;
  logic [2*N-1:0] produto;

  modport master (
    output start, multiplicando, multiplicador,
    input  busy, done, produto
  );

  modport slave (
    input  start, multiplicando, multiplicador,
    output busy, done, produto
  );
endinterface

// File: rtl/mult_soma_desloca.sv
// Sequential unsigned multiplier (shift-and-add). FAST=1 adds and shifts in one cycle;
// FAST=0 spends an extra add cycle for every 1 bit in the multiplier.
module mult_soma_desloca #(
  parameter int N    = 8,
  parameter bit FAST = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  mult_soma_desloca_if.slave  bus,
  output logic [1:0]          state_dbg
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    TEST  = 2'd2,
    SHIFT = 2'd3
  } state_t;

  state_t         state, state_n;
  logic [2*N:0]   acc, acc_n;
  logic [N-1:0]   mcand, mcand_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic           busy, busy_n;
  logic           done, done_n;
  logic [2*N-1:0] produto, produto_n;

  logic [N:0]     addend;
  logic [N:0]     upper_sum;
  logic [2*N:0]   shifted;
  logic           step;
  logic           last;

  always_comb begin
    // The upper part is at most N bits wide before the add, so N+1 bits hold the carry.
    addend    = acc[0] ? {1'b0, mcand} : '0;
    upper_sum = acc[2*N:N] + addend;
    shifted   = acc >> 1;
    last      = (cnt == CW'(N - 1));

    state_n   = state;
    acc_n     = acc;
    mcand_n   = mcand;
    cnt_n     = cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    produto_n = produto;
    step      = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_n   = {{(N + 1){1'b0}}, bus.multiplicador};
          mcand_n = bus.multiplicando;
          cnt_n   = '0;
          busy_n  = 1'b1;
          if (FAST) state_n = RUN;
          else      state_n = TEST;
        end
      end
      RUN: begin
        acc_n = {upper_sum, acc[N-1:0]} >> 1;
        step  = 1'b1;
      end
      TEST: begin
        if (acc[0]) begin
          acc_n   = {upper_sum, acc[N-1:0]};
          state_n = SHIFT;
        end else begin
          acc_n = shifted;
          step  = 1'b1;
        end
      end
      SHIFT: begin
        acc_n   = shifted;
        step    = 1'b1;
        state_n = TEST;
      end
      default: state_n = IDLE;
    endcase

    // Every shift advances the step counter; the N-th shift finishes the operation.
    if (step) begin
      cnt_n = cnt + CW'(1);
      if (last) begin
        produto_n = acc_n[2*N-1:0];
        done_n    = 1'b1;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      produto <= '0;
    end else begin
      state   <= state_n;
      acc     <= acc_n;
      mcand   <= mcand_n;
      cnt     <= cnt_n;
      busy    <= busy_n;
      done    <= done_n;
      produto <= produto_n;
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.produto = produto;
  assign state_dbg   = state;
endmodule

// File: tb/tb_mult_soma_desloca.sv
// Bench for mult_soma_desloca: four instances (N=8/4 x FAST=1/0) against an arithmetic
// reference (product = a*b, latency = N + popcount(b) when not FAST).
module tb_mult_soma_desloca;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  // index: 0 = N8 FAST, 1 = N8 slow, 2 = N4 FAST, 3 = N4 slow
  logic        start_v[4];
  logic [7:0]  a_v[4];
  logic [7:0]  b_v[4];
  logic        busy_v[4];
  logic        done_v[4];
  logic [15:0] prod_v[4];
  logic [1:0]  st_v[4];

  mult_soma_desloca_if #(.N(8)) if0 ();
  mult_soma_desloca_if #(.N(8)) if1 ();
  mult_soma_desloca_if #(.N(4)) if2 ();
  mult_soma_desloca_if #(.N(4)) if3 ();

  mult_soma_desloca #(.N(8), .FAST(1'b1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0), .state_dbg(st_v[0]));
  mult_soma_desloca #(.N(8), .FAST(1'b0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1), .state_dbg(st_v[1]));
  mult_soma_desloca #(.N(4), .FAST(1'b1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2), .state_dbg(st_v[2]));
  mult_soma_desloca #(.N(4), .FAST(1'b0)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3), .state_dbg(st_v[3]));

  assign if0.start = start_v[0];
  assign if0.multiplicando = a_v[0];
  assign if0.multiplicador = b_v[0];
  assign if1.start = start_v[1];
  assign if1.multiplicando = a_v[1];
  assign if1.multiplicador = b_v[1];
  assign if2.start = start_v[2];
  assign if2.multiplicando = a_v[2][3:0];
  assign if2.multiplicador = b_v[2][3:0];
  assign if3.start = start_v[3];
  assign if3.multiplicando = a_v[3][3:0];
  assign if3.multiplicador = b_v[3][3:0];

  assign busy_v[0] = if0.busy;
  assign busy_v[1] = if1.busy;
  assign busy_v[2] = if2.busy;
  assign busy_v[3] = if3.busy;
  assign done_v[0] = if0.done;
  assign done_v[1] = if1.done;
  assign done_v[2] = if2.done;
  assign done_v[3] = if3.done;
  assign prod_v[0] = if0.produto;
  assign prod_v[1] = if1.produto;
  assign prod_v[2] = {8'h00, if2.produto};
  assign prod_v[3] = {8'h00, if3.produto};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_latency(input int sel, input logic [7:0] b);
    int n;
    n = (sel < 2) ? 8 : 4;
    return (sel % 2 == 1) ? n + $countones(b) : n;
  endfunction

  // Counts edges after the start edge until done is seen (sampled 1 time unit after each edge).
  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!done_v[sel] && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!done_v[sel]) check($sformatf("dut%0d done_timeout", sel), 32'(done_v[sel]), 1);
  endtask

  task automatic run_op(input int sel, input logic [7:0] a, input logic [7:0] b);
    int lat;
    logic [15:0] exp;
    @(negedge clk);
    start_v[sel] = 1'b1;
    a_v[sel] = a;
    b_v[sel] = b;
    exp_q.push_back(16'(a) * 16'(b));
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    check($sformatf("dut%0d busy_after_start", sel), 32'(busy_v[sel]), 1);
    wait_done(sel, lat);
    exp = exp_q.pop_front();
    check($sformatf("dut%0d latency a=%0d b=%0d", sel, a, b), lat, ref_latency(sel, b));
    check($sformatf("dut%0d produto a=%0d b=%0d", sel, a, b), 32'(prod_v[sel]), 32'(exp));
    check($sformatf("dut%0d busy_at_done", sel), 32'(busy_v[sel]), 0);
    @(posedge clk);
    #1;
    check($sformatf("dut%0d done_one_cycle", sel), 32'(done_v[sel]), 0);
    check($sformatf("dut%0d produto_hold", sel), 32'(prod_v[sel]), 32'(exp));
  endtask

  initial begin
    int lat;
    int seen;
    for (int i = 0; i < 4; i++) begin
      start_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
    end

    // reset state
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("dut%0d reset busy", i), 32'(busy_v[i]), 0);
      check($sformatf("dut%0d reset done", i), 32'(done_v[i]), 0);
      check($sformatf("dut%0d reset produto", i), 32'(prod_v[i]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // directed corners
    run_op(0, 8'd255, 8'd255);
    run_op(1, 8'd13, 8'd11);
    run_op(1, 8'd0, 8'd0);
    run_op(1, 8'h5D, 8'hFF);
    run_op(0, 8'd0, 8'd0);
    run_op(0, 8'd255, 8'd0);
    run_op(1, 8'd255, 8'd255);

    // start held while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    start_v[0] = 1'b1;
    a_v[0] = 8'd3;
    b_v[0] = 8'd5;
    @(posedge clk);
    #1;
    a_v[0] = 8'd7;
    b_v[0] = 8'd7;
    wait_done(0, lat);
    check("b2b first latency", lat, 8);
    check("b2b first produto", 32'(prod_v[0]), 15);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    check("b2b accepted busy", 32'(busy_v[0]), 1);
    check("b2b produto held", 32'(prod_v[0]), 15);
    wait_done(0, lat);
    check("b2b second latency", lat, 8);
    check("b2b second produto", 32'(prod_v[0]), 49);
    @(posedge clk);
    #1;

    // reset mid-operation aborts without done
    @(negedge clk);
    start_v[0] = 1'b1;
    a_v[0] = 8'd200;
    b_v[0] = 8'd100;
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort busy", 32'(busy_v[0]), 0);
    check("abort done", 32'(done_v[0]), 0);
    check("abort produto", 32'(prod_v[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) seen++;
    end
    check("abort no done pulse", seen, 0);
    check("abort produto stays 0", 32'(prod_v[0]), 0);
    run_op(0, 8'd200, 8'd100);

    // random N=8 stimulus on both variants
    for (int i = 0; i < 30; i++) begin
      run_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      run_op(1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // exhaustive N=4 on both variants
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(2, 8'(a), 8'(b));
        run_op(3, 8'(a), 8'(b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
